// File: rtl/bp_be_pkg.sv
// Back-end shared declarations: configuration selector, writeback packet and long-pipe
// writeback lane state.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_unicore_cfg,
        e_bp_multicore_1_cfg
    } bp_params_e;

    typedef struct packed {
        logic        ird_w_v;
        logic        frd_w_v;
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
        logic [4:0]  fflags;
    } bp_be_wb_pkt_s;

    typedef enum logic {
        e_wb_empty,
        e_wb_full
    } bp_be_long_wb_state_e;

    // Every current configuration shares one writeback packet layout.
    function automatic int unsigned bp_be_wb_pkt_width(bp_params_e cfg);
        case (cfg)
            default: return $bits(bp_be_wb_pkt_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_be_long_wb_retire_if.sv
// One long-pipe writeback lane: producer handshake, regfile write port and stall request.
interface bp_be_long_wb_retire_if
    import bp_be_pkg::*;
#(
    parameter int unsigned pkt_width_p = $bits(bp_be_wb_pkt_s)
);
    logic [pkt_width_p-1:0] pkt;
    logic                   v;
    logic                   yumi;
    logic                   pipe_v;
    logic [pkt_width_p-1:0] rf_pkt;
    logic                   rf_v;
    logic                   stall_req;

    modport master (output pkt, v, pipe_v, input yumi, rf_pkt, rf_v, stall_req);
    modport slave  (input pkt, v, pipe_v, output yumi, rf_pkt, rf_v, stall_req);
endinterface

// File: rtl/bp_be_long_wb_lane.sv
// Single long-pipe writeback lane with starvation counter.
// BP_BE_LONG_WB_SKID_EN adds a one-entry skid register in front of the regfile port.
module bp_be_long_wb_lane
    import bp_be_pkg::*;
#(
    parameter int unsigned pkt_width_p    = $bits(bp_be_wb_pkt_s),
    parameter int unsigned starve_limit_p = 8,
    localparam int unsigned cnt_width_lp  = $clog2(starve_limit_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_be_long_wb_retire_if.slave  wb
);
    localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

    logic                    busy;
    logic                    pending;
    logic                    yumi_raw;
    logic                    rf_v_raw;
    logic [pkt_width_p-1:0]  rf_pkt_raw;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;

    assign busy = wb.pipe_v;

`ifdef BP_BE_LONG_WB_SKID_EN
    bp_be_long_wb_state_e   state_r, state_n;
    logic [pkt_width_p-1:0] skid_r;
    logic                   skid_load;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_r <= e_wb_empty;
        else            state_r <= state_n;
        if (skid_load)  skid_r  <= wb.pkt;
    end

    // The skid always drains before a new packet may reach the port.
    always_comb begin
        state_n    = state_r;
        yumi_raw   = 1'b0;
        rf_v_raw   = 1'b0;
        rf_pkt_raw = wb.pkt;
        skid_load  = 1'b0;
        case (state_r)
            e_wb_empty: begin
                if (wb.v) begin
                    yumi_raw = 1'b1;
                    if (busy) begin
                        skid_load = 1'b1;
                        state_n   = e_wb_full;
                    end else begin
                        rf_v_raw = 1'b1;
                    end
                end
            end
            e_wb_full: begin
                if (!busy) begin
                    rf_v_raw   = 1'b1;
                    rf_pkt_raw = skid_r;
                    if (wb.v) begin
                        yumi_raw  = 1'b1;
                        skid_load = 1'b1;
                    end else begin
                        state_n = e_wb_empty;
                    end
                end
            end
            default: state_n = e_wb_empty;
        endcase
    end

    assign pending = (state_r == e_wb_full) | wb.v;
`else
    assign yumi_raw   = wb.v & ~busy;
    assign rf_v_raw   = yumi_raw;
    assign rf_pkt_raw = wb.pkt;
    assign pending    = wb.v;
`endif

    // A write only happens when the port is free, so "not busy" also covers the clear-on-write case.
    always_comb begin
        cnt_n = '0;
        if (pending && busy)
            cnt_n = (cnt_r == limit_lp) ? cnt_r : cnt_r + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) cnt_r <= '0;
        else            cnt_r <= cnt_n;
    end

    assign wb.yumi      = reset_n_i & yumi_raw;
    assign wb.rf_v      = reset_n_i & rf_v_raw;
    assign wb.rf_pkt    = rf_pkt_raw;
    assign wb.stall_req = reset_n_i & (cnt_r == limit_lp);

endmodule

// File: rtl/bp_be_long_wb_retire.sv
// Retires long-pipe integer and FP writebacks into regfile ports shared with the main pipe.
// Optional skid buffering per lane: BP_BE_LONG_WB_SKID_EN.
module bp_be_long_wb_retire
    import bp_be_pkg::*;
#(
    parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
    parameter int unsigned starve_limit_p = 8,
    localparam int unsigned wb_pkt_width_lp = bp_be_wb_pkt_width(bp_params_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [wb_pkt_width_lp-1:0] iwb_pkt_i,
    input  logic                       iwb_v_i,
    output logic                       iwb_yumi_o,
    input  logic [wb_pkt_width_lp-1:0] fwb_pkt_i,
    input  logic                       fwb_v_i,
    output logic                       fwb_yumi_o,

    input  logic                       pipe_iwb_v_i,
    input  logic                       pipe_fwb_v_i,

    output logic [wb_pkt_width_lp-1:0] irf_pkt_o,
    output logic                       irf_v_o,
    output logic [wb_pkt_width_lp-1:0] frf_pkt_o,
    output logic                       frf_v_o,

    output logic                       istall_req_o,
    output logic                       fstall_req_o
);
    bp_be_long_wb_retire_if #(.pkt_width_p(wb_pkt_width_lp)) iwb_if ();
    bp_be_long_wb_retire_if #(.pkt_width_p(wb_pkt_width_lp)) fwb_if ();

    assign iwb_if.pkt    = iwb_pkt_i;
    assign iwb_if.v      = iwb_v_i;
    assign iwb_if.pipe_v = pipe_iwb_v_i;
    assign iwb_yumi_o    = iwb_if.yumi;
    assign irf_pkt_o     = iwb_if.rf_pkt;
    assign irf_v_o       = iwb_if.rf_v;
    assign istall_req_o  = iwb_if.stall_req;

    assign fwb_if.pkt    = fwb_pkt_i;
    assign fwb_if.v      = fwb_v_i;
    assign fwb_if.pipe_v = pipe_fwb_v_i;
    assign fwb_yumi_o    = fwb_if.yumi;
    assign frf_pkt_o     = fwb_if.rf_pkt;
    assign frf_v_o       = fwb_if.rf_v;
    assign fstall_req_o  = fwb_if.stall_req;

    bp_be_long_wb_lane #(
        .pkt_width_p    (wb_pkt_width_lp),
        .starve_limit_p (starve_limit_p)
    ) int_lane (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wb        (iwb_if)
    );

    bp_be_long_wb_lane #(
        .pkt_width_p    (wb_pkt_width_lp),
        .starve_limit_p (starve_limit_p)
    ) fp_lane (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wb        (fwb_if)
    );

endmodule

// File: tb/tb_bp_be_long_wb_retire.sv
// Directed bench for bp_be_long_wb_retire; covers whichever BP_BE_LONG_WB_SKID_EN build is compiled.
module tb_bp_be_long_wb_retire;
    import bp_be_pkg::*;

    localparam int unsigned W = $bits(bp_be_wb_pkt_s);

    logic clk;
    logic reset_n;
    int unsigned tests = 0;
    int unsigned fails = 0;

    bp_be_long_wb_retire_if #(.pkt_width_p(W)) ii ();
    bp_be_long_wb_retire_if #(.pkt_width_p(W)) fi ();

    bp_be_long_wb_retire #(
        .bp_params_p    (e_bp_default_cfg),
        .starve_limit_p (8)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .iwb_pkt_i    (ii.pkt),
        .iwb_v_i      (ii.v),
        .iwb_yumi_o   (ii.yumi),
        .fwb_pkt_i    (fi.pkt),
        .fwb_v_i      (fi.v),
        .fwb_yumi_o   (fi.yumi),
        .pipe_iwb_v_i (ii.pipe_v),
        .pipe_fwb_v_i (fi.pipe_v),
        .irf_pkt_o    (ii.rf_pkt),
        .irf_v_o      (ii.rf_v),
        .frf_pkt_o    (fi.rf_pkt),
        .frf_v_o      (fi.rf_v),
        .istall_req_o (ii.stall_req),
        .fstall_req_o (fi.stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [W-1:0] mk(logic irdw, logic frdw, logic [4:0] rd,
                                        logic [63:0] d, logic [4:0] ff);
        bp_be_wb_pkt_s p;
        p.ird_w_v = irdw;
        p.frd_w_v = frdw;
        p.rd_addr = rd;
        p.rd_data = d;
        p.fflags  = ff;
        return p;
    endfunction

    logic [W-1:0] pa, pb, pc, pf, pg;

    initial begin
        pa = mk(1'b1, 1'b0, 5'd5,  64'h1234,      5'h00);
        pb = mk(1'b1, 1'b0, 5'd9,  64'hcafe_f00d, 5'h00);
        pc = mk(1'b1, 1'b0, 5'd17, 64'h0bad_0001, 5'h00);
        pf = mk(1'b0, 1'b1, 5'd3,  64'hdead_beef, 5'h01);
        pg = mk(1'b0, 1'b1, 5'd30, 64'h5555_aaaa, 5'h1f);

        // Reset with both lanes offering packets on free ports: every output must stay low.
        reset_n = 1'b0;
        ii.v = 1'b1; ii.pkt = pa; ii.pipe_v = 1'b0;
        fi.v = 1'b1; fi.pkt = pf; fi.pipe_v = 1'b0;
        settle();
        chk("rst_irf_v",  ii.rf_v, 1'b0);
        chk("rst_iyumi",  ii.yumi, 1'b0);
        chk("rst_frf_v",  fi.rf_v, 1'b0);
        chk("rst_fyumi",  fi.yumi, 1'b0);
        chk("rst_istall", ii.stall_req, 1'b0);
        chk("rst_fstall", fi.stall_req, 1'b0);
        tick();
        tick();

        // Direct write on a free integer port.
        reset_n = 1'b1;
        fi.v = 1'b0;
        settle();
        chk("direct_irf_v",   ii.rf_v, 1'b1);
        chk("direct_irf_pkt", ii.rf_pkt, pa);
        chk("direct_iyumi",   ii.yumi, 1'b1);
        chk("direct_frf_v",   fi.rf_v, 1'b0);
        tick();
        ii.v = 1'b0;

`ifdef BP_BE_LONG_WB_SKID_EN
        // FP packet arrives while the port is busy for 3 cycles.
        fi.v = 1'b1; fi.pkt = pf; fi.pipe_v = 1'b1;
        settle();
        chk("fskid_c0_yumi", fi.yumi, 1'b1);
        chk("fskid_c0_v",    fi.rf_v, 1'b0);
        tick();
        fi.v = 1'b0; fi.pkt = pg;
        for (int k = 1; k < 3; k++) begin
            settle();
            chk("fskid_busy_v",    fi.rf_v, 1'b0);
            chk("fskid_busy_yumi", fi.yumi, 1'b0);
            tick();
        end
        fi.pipe_v = 1'b0;
        settle();
        chk("fskid_c3_v",   fi.rf_v, 1'b1);
        chk("fskid_c3_pkt", fi.rf_pkt, pf);
        tick();
        settle();
        chk("fskid_c4_v", fi.rf_v, 1'b0);

        // Skid holds A, B waits, then the port frees: A drains while B is captured.
        ii.v = 1'b1; ii.pkt = pa; ii.pipe_v = 1'b1;
        settle();
        chk("ord_c0_yumi", ii.yumi, 1'b1);
        chk("ord_c0_v",    ii.rf_v, 1'b0);
        tick();
        ii.pkt = pb;
        settle();
        chk("ord_c1_yumi", ii.yumi, 1'b0);
        chk("ord_c1_v",    ii.rf_v, 1'b0);
        tick();
        ii.pipe_v = 1'b0;
        settle();
        chk("ord_c2_v",    ii.rf_v, 1'b1);
        chk("ord_c2_pkt",  ii.rf_pkt, pa);
        chk("ord_c2_yumi", ii.yumi, 1'b1);
        tick();
        ii.v = 1'b0;
        settle();
        chk("ord_c3_v",   ii.rf_v, 1'b1);
        chk("ord_c3_pkt", ii.rf_pkt, pb);
        tick();
        settle();
        chk("ord_c4_v", ii.rf_v, 1'b0);
        tick();

        // Starvation: busy for 10 cycles with one packet pending.
        ii.pipe_v = 1'b1; ii.pkt = pc;
        for (int k = 0; k < 10; k++) begin
            ii.v = (k == 0);
            settle();
            chk("starve_istall", ii.stall_req, 1'(k >= 8));
            if (k == 0) chk("starve_c0_yumi", ii.yumi, 1'b1);
            tick();
        end
        ii.pipe_v = 1'b0;
        settle();
        chk("starve_wr_v",      ii.rf_v, 1'b1);
        chk("starve_wr_pkt",    ii.rf_pkt, pc);
        chk("starve_wr_istall", ii.stall_req, 1'b1);
        chk("starve_fstall",    fi.stall_req, 1'b0);
        tick();
        settle();
        chk("starve_after_istall", ii.stall_req, 1'b0);
        chk("starve_after_v",      ii.rf_v, 1'b0);
        tick();

        // Reset while the FP skid is full must discard the packet.
        fi.v = 1'b1; fi.pkt = pg; fi.pipe_v = 1'b1;
        settle();
        chk("rstfull_cap_yumi", fi.yumi, 1'b1);
        tick();
        reset_n = 1'b0; fi.v = 1'b0; fi.pipe_v = 1'b0;
        ii.v = 1'b1; ii.pkt = pa;
        settle();
        chk("rstfull_frf_v", fi.rf_v, 1'b0);
        chk("rstfull_fyumi", fi.yumi, 1'b0);
        chk("rstfull_irf_v", ii.rf_v, 1'b0);
        chk("rstfull_iyumi", ii.yumi, 1'b0);
        tick();
        reset_n = 1'b1; ii.v = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("rstfull_stale_v", fi.rf_v, 1'b0);
            tick();
        end
`else
        // Busy port: no handshake until it frees, then consume and write together.
        ii.v = 1'b1; ii.pkt = pb; ii.pipe_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("pass_busy_yumi", ii.yumi, 1'b0);
            chk("pass_busy_v",    ii.rf_v, 1'b0);
            tick();
        end
        ii.pipe_v = 1'b0;
        settle();
        chk("pass_free_yumi", ii.yumi, 1'b1);
        chk("pass_free_v",    ii.rf_v, 1'b1);
        chk("pass_free_pkt",  ii.rf_pkt, pb);
        tick();
        ii.v = 1'b0;

        // FP lane passthrough, fflags preserved, then blocked by its own port.
        fi.v = 1'b1; fi.pkt = pf; fi.pipe_v = 1'b0;
        settle();
        chk("fpass_v",    fi.rf_v, 1'b1);
        chk("fpass_pkt",  fi.rf_pkt, pf);
        chk("fpass_yumi", fi.yumi, 1'b1);
        tick();
        fi.pipe_v = 1'b1;
        settle();
        chk("fbusy_yumi", fi.yumi, 1'b0);
        chk("fbusy_v",    fi.rf_v, 1'b0);
        tick();
        fi.v = 1'b0; fi.pipe_v = 1'b0;

        // Starvation: 10 busy cycles, counter saturates at the limit.
        ii.v = 1'b1; ii.pkt = pc; ii.pipe_v = 1'b1;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("starve_istall", ii.stall_req, 1'(k >= 8));
            chk("starve_yumi",   ii.yumi, 1'b0);
            tick();
        end
        ii.pipe_v = 1'b0;
        settle();
        chk("starve_wr_yumi",   ii.yumi, 1'b1);
        chk("starve_wr_v",      ii.rf_v, 1'b1);
        chk("starve_wr_istall", ii.stall_req, 1'b1);
        chk("starve_fstall",    fi.stall_req, 1'b0);
        tick();
        ii.v = 1'b0;
        settle();
        chk("starve_after_istall", ii.stall_req, 1'b0);
        tick();

        // Reset mid-starvation clears the counter.
        ii.v = 1'b1; ii.pipe_v = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        reset_n = 1'b0;
        fi.v = 1'b1; fi.pkt = pg;
        settle();
        chk("midrst_frf_v", fi.rf_v, 1'b0);
        chk("midrst_fyumi", fi.yumi, 1'b0);
        tick();
        reset_n = 1'b1; fi.v = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("midrst_istall", ii.stall_req, 1'b0);
            tick();
        end
`endif

        ii.v = 1'b0; ii.pipe_v = 1'b0;
        fi.v = 1'b0; fi.pipe_v = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
